// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM command arbiter.
//   CMD_WIDTH / ADDR_WIDTH / DATA_WIDTH : command word geometry
//   WE_BIT, ADDR_LSB, DATA_LSB          : field offsets inside a command word
//   rsp_state_t                         : read-response FSM states
package sdram_arb_pkg;
   localparam int CMD_WIDTH  = 41;
   localparam int ADDR_WIDTH = 24;
   localparam int DATA_WIDTH = 16;
   localparam int WE_BIT     = 40;
   localparam int ADDR_LSB   = 16;
   localparam int DATA_LSB   = 0;

   typedef enum logic [1:0] {
      RSP_IDLE,
      RSP_CAPTURE,
      RSP_PRESENT
   } rsp_state_t;
endpackage

// File: rtl/tag_fifo.sv
// Synchronous 1-bit FIFO holding the requester ID of each outstanding read.
//   clk, rst_i  : clock, synchronous active-high reset (empties the FIFO)
//   push, din   : write one ID (ignored when full)
//   pop, dout   : drop the head ID (ignored when empty); dout is the head
//   full, empty : occupancy flags; push and pop in the same cycle are legal
module tag_fifo #(
   parameter int DEPTH = 16
) (
   input  logic clk,
   input  logic rst_i,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic dout,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/sdram_cmd_arbiter.sv
// Two-requester round-robin arbiter in front of the SDRAM command FIFO, with
// in-order routing of single-word read data back to the issuing requester.
//   req0_*/req1_*   : command request (valid/ready, we, addr, data)
//   rsp0_*/rsp1_*   : read response (valid/ready, data)
//   cmd_d_o/enq     : registered command word and enqueue pulse to cmd FIFO
//   cmd_full_i/alm  : cmd FIFO back-pressure
//   rd_q_i/deq/empty: read-data FIFO (data valid the cycle after a dequeue)
//   outstanding_o   : reads issued and not yet returned
//   err_o           : sticky, read data arrived with no outstanding tag
module sdram_cmd_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int TAG_DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_i,
   input  logic                         req0_valid_i,
   output logic                         req0_ready_o,
   input  logic                         req0_we_i,
   input  logic [ADDR_WIDTH-1:0]        req0_addr_i,
   input  logic [DATA_WIDTH-1:0]        req0_data_i,
   input  logic                         req1_valid_i,
   output logic                         req1_ready_o,
   input  logic                         req1_we_i,
   input  logic [ADDR_WIDTH-1:0]        req1_addr_i,
   input  logic [DATA_WIDTH-1:0]        req1_data_i,
   output logic                         rsp0_valid_o,
   output logic [DATA_WIDTH-1:0]        rsp0_data_o,
   input  logic                         rsp0_ready_i,
   output logic                         rsp1_valid_o,
   output logic [DATA_WIDTH-1:0]        rsp1_data_o,
   input  logic                         rsp1_ready_i,
   output logic [CMD_WIDTH-1:0]         cmd_d_o,
   output logic                         cmd_enq_o,
   input  logic                         cmd_full_i,
   input  logic                         cmd_alm_full_i,
   input  logic [DATA_WIDTH-1:0]        rd_q_i,
   output logic                         rd_deq_o,
   input  logic                         rd_empty_i,
   output logic [$clog2(TAG_DEPTH):0]   outstanding_o,
   output logic                         err_o
);
   localparam int OW = $clog2(TAG_DEPTH) + 1;

   logic                  elig_wr, elig_rd, elig0, elig1, gnt0, gnt1;
   logic                  last_grant;   // 1: req1 was granted last
   logic                  acc, acc_we;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [DATA_WIDTH-1:0] acc_data;
   logic                  tag_push, tag_pop, tag_dout, tag_full, tag_empty;
   logic                  deq, err_set;
   logic                  rsp_id;
   logic [DATA_WIDTH-1:0] rsp_data;
   rsp_state_t            state, state_nx;

   // Reads also need a free tag slot, so a full tag FIFO blocks only reads.
   assign elig_wr = ~cmd_full_i & ~cmd_alm_full_i;
   assign elig_rd = elig_wr & ~tag_full;
   assign elig0   = req0_valid_i & (req0_we_i ? elig_wr : elig_rd);
   assign elig1   = req1_valid_i & (req1_we_i ? elig_wr : elig_rd);
   assign gnt0    = ~rst_i & elig0 & (~elig1 | last_grant);
   assign gnt1    = ~rst_i & elig1 & (~elig0 | ~last_grant);

   assign req0_ready_o = gnt0;
   assign req1_ready_o = gnt1;

   assign acc      = gnt0 | gnt1;
   assign acc_we   = gnt1 ? req1_we_i   : req0_we_i;
   assign acc_addr = gnt1 ? req1_addr_i : req0_addr_i;
   assign acc_data = gnt1 ? req1_data_i : req0_data_i;
   assign tag_push = acc & ~acc_we;

   tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
      .clk   (clk),
      .rst_i (rst_i),
      .push  (tag_push),
      .din   (gnt1),
      .pop   (tag_pop),
      .dout  (tag_dout),
      .full  (tag_full),
      .empty (tag_empty)
   );

   always_comb begin
      state_nx = state;
      deq      = 1'b0;
      tag_pop  = 1'b0;
      err_set  = 1'b0;
      case (state)
         RSP_IDLE: begin
            if (!rd_empty_i) begin
               if (!tag_empty) begin
                  deq      = 1'b1;
                  state_nx = RSP_CAPTURE;
               end else begin
                  err_set  = 1'b1;
               end
            end
         end
         RSP_CAPTURE: begin
            tag_pop  = 1'b1;
            state_nx = RSP_PRESENT;
         end
         RSP_PRESENT: begin
            if (rsp_id ? rsp1_ready_i : rsp0_ready_i) state_nx = RSP_IDLE;
         end
         default: state_nx = RSP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state         <= RSP_IDLE;
         last_grant    <= 1'b1;
         cmd_enq_o     <= 1'b0;
         cmd_d_o       <= '0;
         outstanding_o <= '0;
         err_o         <= 1'b0;
         rsp_id        <= 1'b0;
         rsp_data      <= '0;
      end else begin
         state     <= state_nx;
         cmd_enq_o <= acc;
         if (acc) begin
            cmd_d_o    <= {acc_we, acc_addr, acc_data};
            last_grant <= gnt1;
         end
         case ({tag_push, tag_pop})
            2'b10:   outstanding_o <= outstanding_o + OW'(1);
            2'b01:   outstanding_o <= outstanding_o - OW'(1);
            default: outstanding_o <= outstanding_o;
         endcase
         if (err_set) err_o <= 1'b1;
         // Data FIFO output is valid the cycle after the dequeue pulse.
         if (state == RSP_CAPTURE) begin
            rsp_data <= rd_q_i;
            rsp_id   <= tag_dout;
         end
      end
   end

   assign rd_deq_o     = deq & ~rst_i;
   assign rsp0_valid_o = (state == RSP_PRESENT) & ~rsp_id;
   assign rsp1_valid_o = (state == RSP_PRESENT) &  rsp_id;
   assign rsp0_data_o  = rsp_data;
   assign rsp1_data_o  = rsp_data;
endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
module tb_sdram_cmd_arbiter;
   localparam int TD = 16;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req0_valid_i, req0_ready_o, req0_we_i;
   logic [23:0] req0_addr_i;
   logic [15:0] req0_data_i;
   logic        req1_valid_i, req1_ready_o, req1_we_i;
   logic [23:0] req1_addr_i;
   logic [15:0] req1_data_i;
   logic        rsp0_valid_o, rsp0_ready_i, rsp1_valid_o, rsp1_ready_i;
   logic [15:0] rsp0_data_o, rsp1_data_o;
   logic [40:0] cmd_d_o;
   logic        cmd_enq_o, cmd_full_i, cmd_alm_full_i;
   logic [15:0] rd_q_i;
   logic        rd_deq_o, rd_empty_i;
   logic [4:0]  outstanding_o;
   logic        err_o;

   int n_vec = 0;
   int n_err = 0;

   // Read-data FIFO model: pushed by the stimulus, popped by the DUT with
   // one cycle of read latency.
   logic [15:0] df_mem [64];
   int df_wr = 0;
   int df_rd = 0;
   assign rd_empty_i = (df_wr == df_rd);

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_i) begin
         df_rd  <= df_wr;
         rd_q_i <= '0;
      end else if (rd_deq_o) begin
         rd_q_i <= df_mem[df_rd[5:0]];
         df_rd  <= df_rd + 1;
      end
   end

   sdram_cmd_arbiter #(.TAG_DEPTH(TD)) dut (
      .clk(clk), .rst_i(rst_i),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
      .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
      .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
      .rsp0_valid_o(rsp0_valid_o), .rsp0_data_o(rsp0_data_o), .rsp0_ready_i(rsp0_ready_i),
      .rsp1_valid_o(rsp1_valid_o), .rsp1_data_o(rsp1_data_o), .rsp1_ready_i(rsp1_ready_i),
      .cmd_d_o(cmd_d_o), .cmd_enq_o(cmd_enq_o),
      .cmd_full_i(cmd_full_i), .cmd_alm_full_i(cmd_alm_full_i),
      .rd_q_i(rd_q_i), .rd_deq_o(rd_deq_o), .rd_empty_i(rd_empty_i),
      .outstanding_o(outstanding_o), .err_o(err_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, ".rdy0"},  64'(req0_ready_o),  0);
      chk({tag, ".rdy1"},  64'(req1_ready_o),  0);
      chk({tag, ".enq"},   64'(cmd_enq_o),     0);
      chk({tag, ".cmd_d"}, 64'(cmd_d_o),       0);
      chk({tag, ".deq"},   64'(rd_deq_o),      0);
      chk({tag, ".rv0"},   64'(rsp0_valid_o),  0);
      chk({tag, ".rv1"},   64'(rsp1_valid_o),  0);
      chk({tag, ".rd0"},   64'(rsp0_data_o),   0);
      chk({tag, ".rd1"},   64'(rsp1_data_o),   0);
      chk({tag, ".outst"}, 64'(outstanding_o), 0);
      chk({tag, ".err"},   64'(err_o),         0);
   endtask

   // Called at a negedge; optionally checks outputs one cycle into reset.
   task automatic do_reset(input bit chk_out);
      rst_i = 1'b1;
      req0_valid_i = 0; req1_valid_i = 0; rsp0_ready_i = 0; rsp1_ready_i = 0;
      cmd_full_i = 0; cmd_alm_full_i = 0;
      @(negedge clk); #1;
      if (chk_out) chk_reset_outs("rst_mid");
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   task automatic push_data(input logic [15:0] d);
      df_mem[df_wr[5:0]] = d;
      df_wr = df_wr + 1;
   endtask

   initial begin
      rst_i = 1; cmd_full_i = 0; cmd_alm_full_i = 0;
      rsp0_ready_i = 0; rsp1_ready_i = 0;
      req0_valid_i = 1; req0_we_i = 0; req0_addr_i = '0; req0_data_i = '0;
      req1_valid_i = 1; req1_we_i = 0; req1_addr_i = '0; req1_data_i = '0;
      repeat (2) @(negedge clk);
      #1;
      chk_reset_outs("rst");
      req0_valid_i = 0; req1_valid_i = 0;
      @(negedge clk);
      rst_i = 0;

      // Single write from req0.
      req0_valid_i = 1; req0_we_i = 1; req0_addr_i = 24'h000010; req0_data_i = 16'hBEEF;
      #1;
      chk("wr.rdy0", 64'(req0_ready_o), 1);
      chk("wr.rdy1", 64'(req1_ready_o), 0);
      chk("wr.enq_same", 64'(cmd_enq_o), 0);
      @(negedge clk);
      req0_valid_i = 0;
      #1;
      chk("wr.enq", 64'(cmd_enq_o), 1);
      chk("wr.cmd_d", 64'(cmd_d_o), 64'h1_000010_BEEF);
      chk("wr.outst", 64'(outstanding_o), 0);
      @(negedge clk); #1;
      chk("wr.enq_drop", 64'(cmd_enq_o), 0);

      // Both requesters reading continuously: alternate 0,1,0,1.
      do_reset(0);
      req0_valid_i = 1; req0_we_i = 0; req0_addr_i = 24'h000100; req0_data_i = 0;
      req1_valid_i = 1; req1_we_i = 0; req1_addr_i = 24'h000200; req1_data_i = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr.rdy0", 64'(req0_ready_o), (i % 2 == 0) ? 1 : 0);
         chk("rr.rdy1", 64'(req1_ready_o), (i % 2 == 1) ? 1 : 0);
         @(negedge clk); #1;
         chk("rr.enq", 64'(cmd_enq_o), 1);
         chk("rr.cmd_d", 64'(cmd_d_o), (i % 2 == 0) ? 64'h0_000100_0000 : 64'h0_000200_0000);
         chk("rr.outst", 64'(outstanding_o), 64'(i + 1));
      end

      // Almost-full blocks everything; round-robin resumes with req0.
      cmd_alm_full_i = 1;
      #1;
      chk("af.rdy0", 64'(req0_ready_o), 0);
      chk("af.rdy1", 64'(req1_ready_o), 0);
      @(negedge clk); #1;
      chk("af.enq", 64'(cmd_enq_o), 0);
      chk("af.rdy0b", 64'(req0_ready_o), 0);
      cmd_alm_full_i = 0;
      #1;
      chk("af.resume0", 64'(req0_ready_o), 1);
      chk("af.resume1", 64'(req1_ready_o), 0);
      @(negedge clk); #1;
      chk("af.enq2", 64'(cmd_enq_o), 1);
      chk("af.next1", 64'(req1_ready_o), 1);
      chk("af.outst", 64'(outstanding_o), 5);
      req0_valid_i = 0; req1_valid_i = 0;

      // req1 read then req0 read; responses delivered in order.
      do_reset(0);
      req1_valid_i = 1; req1_we_i = 0; req1_addr_i = 24'h000300;
      #1;
      chk("io.rdy1", 64'(req1_ready_o), 1);
      @(negedge clk);
      req1_valid_i = 0;
      req0_valid_i = 1; req0_we_i = 0; req0_addr_i = 24'h000400;
      #1;
      chk("io.rdy0", 64'(req0_ready_o), 1);
      @(negedge clk);
      req0_valid_i = 0;
      #1;
      chk("io.outst2", 64'(outstanding_o), 2);
      push_data(16'h1111);
      push_data(16'h2222);
      for (int k = 0; k < 20 && !rsp1_valid_o; k++) begin
         @(negedge clk); #1;
      end
      chk("io.rv1", 64'(rsp1_valid_o), 1);
      chk("io.rv0", 64'(rsp0_valid_o), 0);
      chk("io.rd1", 64'(rsp1_data_o), 16'h1111);
      chk("io.rd0_mirror", 64'(rsp0_data_o), 16'h1111);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk("io.hold_v", 64'(rsp1_valid_o), 1);
         chk("io.hold_d", 64'(rsp1_data_o), 16'h1111);
      end
      rsp1_ready_i = 1;
      @(negedge clk);
      rsp1_ready_i = 0;
      #1;
      chk("io.rv1_drop", 64'(rsp1_valid_o), 0);
      for (int k = 0; k < 20 && !rsp0_valid_o; k++) begin
         @(negedge clk); #1;
      end
      chk("io.rv0b", 64'(rsp0_valid_o), 1);
      chk("io.rv1b", 64'(rsp1_valid_o), 0);
      chk("io.rd0b", 64'(rsp0_data_o), 16'h2222);
      chk("io.outst0", 64'(outstanding_o), 0);
      rsp0_ready_i = 1;
      @(negedge clk);
      rsp0_ready_i = 0;
      #1;
      chk("io.rv0_drop", 64'(rsp0_valid_o), 0);

      // Tag FIFO full: reads blocked, writes still flow.
      do_reset(0);
      req0_valid_i = 1; req0_we_i = 0; req0_addr_i = 24'h000500;
      repeat (TD) @(negedge clk);
      #1;
      chk("tf.outst", 64'(outstanding_o), TD);
      chk("tf.rdy0_blk", 64'(req0_ready_o), 0);
      req1_valid_i = 1; req1_we_i = 1; req1_addr_i = 24'h000600; req1_data_i = 16'h00AA;
      #1;
      chk("tf.wr_rdy1", 64'(req1_ready_o), 1);
      chk("tf.rdy0_blk2", 64'(req0_ready_o), 0);
      @(negedge clk);
      req1_valid_i = 0;
      #1;
      chk("tf.wr_cmd", 64'(cmd_d_o), 64'h1_000600_00AA);
      push_data(16'h5555);
      for (int k = 0; k < 20 && !req0_ready_o; k++) begin
         @(negedge clk); #1;
      end
      chk("tf.rdy0_free", 64'(req0_ready_o), 1);
      chk("tf.outst15", 64'(outstanding_o), TD - 1);
      @(negedge clk);
      req0_valid_i = 0;

      // Orphan read data: sticky error, no dequeue.
      do_reset(0);
      push_data(16'h7777);
      @(negedge clk); #1;
      chk("er.err", 64'(err_o), 1);
      chk("er.deq", 64'(rd_deq_o), 0);
      repeat (3) @(negedge clk);
      #1;
      chk("er.sticky", 64'(err_o), 1);
      chk("er.deq2", 64'(rd_deq_o), 0);

      // Reset while a response is being presented.
      do_reset(0);
      req0_valid_i = 1; req0_we_i = 0; req0_addr_i = 24'h000700;
      @(negedge clk);
      req0_valid_i = 0;
      push_data(16'hABCD);
      for (int k = 0; k < 20 && !rsp0_valid_o; k++) begin
         @(negedge clk); #1;
      end
      chk("rp.rv0", 64'(rsp0_valid_o), 1);
      chk("rp.rd0", 64'(rsp0_data_o), 16'hABCD);
      @(negedge clk);
      do_reset(1);
      #1;
      chk("rp.after_rv0", 64'(rsp0_valid_o), 0);
      chk("rp.after_outst", 64'(outstanding_o), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sdram_cmd_arbiter.md
SDRAM_CMD_ARBITER -- requirements
Module: sdram_cmd_arbiter

Interface
REQ-001 Parameter TAG_DEPTH, default 16, power of 2: maximum number of single-word reads outstanding.
REQ-002 clk  in  1  sole clock; drives the cmd FIFO writer side and the single-word data FIFO reader side.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 reqN_valid_i  in  1  (N=0,1) requester N has a command.
REQ-005 reqN_ready_o  in/out  out 1  combinational grant; command accepted when valid&ready.
REQ-006 reqN_we_i  in  1  1=write, 0=read.
REQ-007 reqN_addr_i  in  24  word address.
REQ-008 reqN_data_i  in  16  write data; ignored for reads.
REQ-009 rspN_valid_o  out  1  read data for requester N is valid.
REQ-010 rspN_data_o  out  16  read data.
REQ-011 rspN_ready_i  in  1  requester N takes the response.
REQ-012 cmd_d_o  out  41  {we, addr[23:0], data[15:0]} to cmd FIFO writer.
REQ-013 cmd_enq_o  out  1  cmd FIFO enqueue, single-cycle pulse.
REQ-014 cmd_full_i / cmd_alm_full_i  in  1 each  cmd FIFO full / almost full.
REQ-015 rd_q_i  in  16  single-word data FIFO output.
REQ-016 rd_deq_o  out  1  data FIFO dequeue pulse.
REQ-017 rd_empty_i  in  1  data FIFO empty.
REQ-018 outstanding_o  out  $clog2(TAG_DEPTH)+1  reads issued and not yet returned.
REQ-019 err_o  out  1  sticky: data arrived with no outstanding tag.

Function
REQ-020 Grant eligibility: cmd_full_i=0 and cmd_alm_full_i=0; read additionally requires tag FIFO not full.
REQ-021 At most one reqN_ready_o high per cycle; ready is never high for a requester with valid low.
REQ-022 Arbitration is round-robin: both eligible -> grant the one not granted last; last_grant resets to 1 (req0 wins first tie).
REQ-023 Accepted command appears on cmd_d_o with cmd_enq_o=1 exactly one cycle after acceptance; cmd_enq_o=0 otherwise.
REQ-024 Back-to-back grants are allowed: one command per cycle sustained while eligible.
REQ-025 Accepted read pushes requester ID into tag FIFO in the acceptance cycle; writes push nothing.
REQ-026 Response FSM states: RSP_IDLE, RSP_CAPTURE, RSP_PRESENT.
REQ-027 RSP_IDLE: if rd_empty_i=0 and tag FIFO non-empty -> rd_deq_o=1 for one cycle, go RSP_CAPTURE.
REQ-028 RSP_CAPTURE: latch rd_q_i into rsp data, pop tag into rsp_id, go RSP_PRESENT.
REQ-029 RSP_PRESENT: rsp[rsp_id]_valid_o=1, other valid 0; on rsp[rsp_id]_ready_i=1 go RSP_IDLE.
REQ-030 rspN_data_o holds the latched value for both N; only valid differs.
REQ-031 Responses are delivered in issue order, tag FIFO matching the in-order cmd/data FIFOs.
REQ-032 outstanding_o +1 on read accept, -1 on tag pop, unchanged if both in same cycle.
REQ-033 rd_empty_i=0 with tag FIFO empty in RSP_IDLE: no dequeue, err_o set and held until reset.
REQ-034 Requester holding valid while ineligible keeps its command stable; arbiter imposes no timeout.

Reset
REQ-035 On rst_i: reqN_ready_o=0, cmd_enq_o=0, cmd_d_o=0, rd_deq_o=0, rspN_valid_o=0, rspN_data_o=0, outstanding_o=0, err_o=0, tag FIFO empty, FSM RSP_IDLE, last_grant=1.
REQ-036 Reset mid-operation discards tags and pending response; the SDRAM side and data FIFO are reset together with this block.

Structure
REQ-037 Package sdram_arb_pkg holds CMD_WIDTH=41, ADDR_WIDTH=24, DATA_WIDTH=16, cmd field offsets (WE_BIT=40) and the response FSM enum.
REQ-038 Sub-module tag_fifo: synchronous FIFO, 1-bit data, depth TAG_DEPTH, push/pop/full/empty, push+pop same cycle legal.
REQ-039 Burst commands are not arbitrated by this block.

Verification
REQ-040 req0 write addr 0x000010 data 0xBEEF, FIFO idle -> ready0 same cycle, cmd_d_o=0x1_000010_BEEF with enq next cycle, no tag.
REQ-041 req0 and req1 reads held valid continuously -> grants alternate 0,1,0,1, one per cycle, outstanding_o counts 1..4.
REQ-042 cmd_alm_full_i=1 with both valid -> no ready, no enq; deassert -> grant resumes next cycle, round-robin order kept.
REQ-043 req1 read then req0 read, data 0x1111 then 0x2222 -> rsp1_valid with 0x1111, then rsp0_valid with 0x2222; rsp1_ready held low 5 cycles keeps valid and data stable.
REQ-044 TAG_DEPTH reads outstanding -> further read blocked, write from other requester still granted; one response pop -> read granted.
REQ-045 rd_empty_i=0 with outstanding_o=0 -> err_o=1, rd_deq_o stays 0; rst_i mid-RSP_PRESENT -> all outputs at reset values next cycle.
